// File: rtl/mapa_pkg.sv
// Shared types and constants for the distance-measurement front-end of the
// occupancy-grid mapper.
//   estado_t       : measurement state machine states
//   SENSOR_*       : sensor index (also bit position in eco/disparo)
//   HORIZONTAL/VERTICAL : direction encoding of direcao
//   sensor_onehot  : index -> one-hot trigger pattern
package mapa_pkg;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        DISPARO    = 3'd1,
        ESPERA_ECO = 3'd2,
        MEDINDO    = 3'd3,
        PROXIMO    = 3'd4,
        ENTREGA    = 3'd5,
        AGUARDA    = 3'd6
    } estado_t;

    localparam logic [1:0] SENSOR_FRENTE   = 2'd0;
    localparam logic [1:0] SENSOR_DIREITA  = 2'd1;
    localparam logic [1:0] SENSOR_ESQUERDA = 2'd2;

    localparam logic HORIZONTAL = 1'b0;
    localparam logic VERTICAL   = 1'b1;

    function automatic logic [2:0] sensor_onehot(input logic [1:0] indice);
        case (indice)
            SENSOR_FRENTE:   sensor_onehot = 3'b001;
            SENSOR_DIREITA:  sensor_onehot = 3'b010;
            SENSOR_ESQUERDA: sensor_onehot = 3'b100;
            default:         sensor_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/medidor_distancias_if.sv
// Sample hand-off between the distance meter and the occupancy-grid mapper.
//   operacaoFinalizada : mapper ready (mapper -> meter)
//   novoDado           : one-cycle sample-valid pulse (meter -> mapper)
//   posicaoAtualnoEixoX/Y, direcaoAtual : latched pose of the sample
//   distanciaFrente/Direita/Esquerda    : clamped distances in cells
// modport master: the meter; modport slave: the mapper.
interface medidor_distancias_if #(
    parameter int tamanhoDistancia = 8
);
    logic                        operacaoFinalizada;
    logic                        novoDado;
    logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX;
    logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY;
    logic                        direcaoAtual;
    logic [tamanhoDistancia-1:0] distanciaFrente;
    logic [tamanhoDistancia-1:0] distanciaDireita;
    logic [tamanhoDistancia-1:0] distanciaEsquerda;

    modport master (
        input  operacaoFinalizada,
        output novoDado, posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
        output distanciaFrente, distanciaDireita, distanciaEsquerda
    );

    modport slave (
        output operacaoFinalizada,
        input  novoDado, posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
        input  distanciaFrente, distanciaDireita, distanciaEsquerda
    );
endinterface

// File: rtl/medidor_eco.sv
// Echo front-end shared by the three ultrasonic sensors.
// Synchronizes all echo inputs (2 flops), selects the active sensor, detects
// rising/falling edges and runs the cycle/cell counters (cells saturate at
// TamanhoMalha-1).
//   clock, reset : clock, asynchronous active-low reset
//   eco          : raw asynchronous echo inputs
//   indice       : active sensor
//   limpar       : clear cycle and cell counters
//   contar       : advance counters this cycle
//   sobe, desce  : synchronized edge of the selected echo
//   celula_prox  : cell count including the current cycle
module medidor_eco import mapa_pkg::*; #(
    parameter int TamanhoMalha     = 20,
    parameter int tamanhoDistancia = 8,
    parameter int CiclosPorCelula  = 29000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [2:0]                  eco,
    input  logic [1:0]                  indice,
    input  logic                        limpar,
    input  logic                        contar,
    output logic                        sobe,
    output logic                        desce,
    output logic [tamanhoDistancia-1:0] celula_prox
);
    localparam int CW = (CiclosPorCelula > 1) ? $clog2(CiclosPorCelula) : 1;
    localparam logic [CW-1:0] CICLO_ULTIMO = CW'(CiclosPorCelula - 1);
    localparam logic [tamanhoDistancia-1:0] CELULA_MAX = tamanhoDistancia'(TamanhoMalha - 1);

    logic [2:0]                  sinc1_r, sinc2_r;
    logic                        anterior_r;
    logic                        eco_sel_s;
    logic [CW-1:0]               ciclo_r, ciclo_prox_s;
    logic [tamanhoDistancia-1:0] celula_r;

    // Selected synchronized echo and its edges against last cycle's value.
    always_comb begin
        case (indice)
            SENSOR_DIREITA:  eco_sel_s = sinc2_r[1];
            SENSOR_ESQUERDA: eco_sel_s = sinc2_r[2];
            default:         eco_sel_s = sinc2_r[0];
        endcase
        sobe  = eco_sel_s & ~anterior_r;
        desce = ~eco_sel_s & anterior_r;
    end

    // Next counter values; the cell count holds at the grid edge.
    always_comb begin
        if (ciclo_r == CICLO_ULTIMO) begin
            ciclo_prox_s = '0;
            celula_prox  = (celula_r == CELULA_MAX) ? celula_r : celula_r + 1'b1;
        end else begin
            ciclo_prox_s = ciclo_r + 1'b1;
            celula_prox  = celula_r;
        end
    end

    // Two-flop synchronizer and edge-detect history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1_r    <= 3'b000;
            sinc2_r    <= 3'b000;
            anterior_r <= 1'b0;
        end else begin
            sinc1_r    <= eco;
            sinc2_r    <= sinc1_r;
            anterior_r <= eco_sel_s;
        end
    end

    // Cycle and cell counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ciclo_r  <= '0;
            celula_r <= '0;
        end else if (limpar) begin
            ciclo_r  <= '0;
            celula_r <= '0;
        end else if (contar) begin
            ciclo_r  <= ciclo_prox_s;
            celula_r <= celula_prox;
        end
    end
endmodule

// File: rtl/medidor_distancias.sv
// Ultrasonic distance meter feeding the occupancy-grid mapper.
// Fires front, right and left sensors in turn, converts each echo width to
// grid cells, clamps against the grid bounds for the latched pose and hands
// one sample to the mapper (novoDado, gated by operacaoFinalizada).
//   clock, reset  : clock, asynchronous active-low reset
//   iniciar       : start a measurement cycle (idle only)
//   posicaoX/Y, direcao : pose, latched at start
//   eco / disparo : echo inputs / one-hot trigger outputs (bit0 front,
//                   bit1 right, bit2 left)
//   timeoutSensor : per sensor, echo wait expired during the current sample
//   ocupado       : high whenever not idle
//   mapa          : sample hand-off to the mapper (master side)
// Build option: MEDIDOR_CONTINUO_EN -- re-measure back to back, iniciar ignored.
module medidor_distancias import mapa_pkg::*; #(
    parameter int TamanhoMalha     = 20,
    parameter int tamanhoDistancia = 8,
    parameter int CiclosPorCelula  = 29000,
    parameter int CiclosDisparo    = 500,
    parameter int CiclosTimeout    = 1200000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        iniciar,
    input  logic [tamanhoDistancia-1:0] posicaoX,
    input  logic [tamanhoDistancia-1:0] posicaoY,
    input  logic                        direcao,
    input  logic [2:0]                  eco,
    output logic [2:0]                  disparo,
    output logic [2:0]                  timeoutSensor,
    output logic                        ocupado,
    medidor_distancias_if.master        mapa
);
    localparam int W  = tamanhoDistancia;
    // One timer serves trigger length and both timeouts (timeout is the longest).
    localparam int TW = $clog2(CiclosTimeout + 1);
    localparam logic [TW-1:0] TIMEOUT_ULTIMO = TW'(CiclosTimeout - 1);
    localparam logic [TW-1:0] DISPARO_ULTIMO = TW'(CiclosDisparo - 1);
    localparam logic [W-1:0]  DIST_MAX = W'(TamanhoMalha - 1);
    localparam logic [W-1:0]  DIST_UM  = W'(1);

    estado_t       estado_r;
    logic [1:0]    indice_r;
    logic [TW-1:0] timer_r;
    logic [W-1:0]  dist_bruta_r, dist_frente_r, dist_dir_r, dist_esq_r;
    logic [W-1:0]  pos_x_r, pos_y_r;
    logic          dir_r, novo_dado_r, ocupado_r;
    logic [2:0]    disparo_r, timeout_r;

    logic          partida_s, limpar_s, contar_s, sobe_s, desce_s;
    logic [W-1:0]  celula_prox_s, coord_s, d_min_s, lim_s, dist_limitada_s;

`ifdef MEDIDOR_CONTINUO_EN
    assign partida_s = 1'b1 | iniciar;
`else
    assign partida_s = iniciar;
`endif

    assign limpar_s = (estado_r == ESPERA_ECO) && sobe_s;
    assign contar_s = (estado_r == MEDINDO);

    medidor_eco #(
        .TamanhoMalha     (TamanhoMalha),
        .tamanhoDistancia (tamanhoDistancia),
        .CiclosPorCelula  (CiclosPorCelula)
    ) u_eco (
        .clock       (clock),
        .reset       (reset),
        .eco         (eco),
        .indice      (indice_r),
        .limpar      (limpar_s),
        .contar      (contar_s),
        .sobe        (sobe_s),
        .desce       (desce_s),
        .celula_prox (celula_prox_s)
    );

    // Clamp the raw distance of the current sensor against the grid bounds.
    // A zero bound yields 0: the robot is against that wall.
    always_comb begin
        case (dir_r)
            VERTICAL:   coord_s = pos_x_r;
            HORIZONTAL: coord_s = pos_y_r;
            default:    coord_s = pos_y_r;
        endcase
        d_min_s = (dist_bruta_r == '0) ? DIST_UM : dist_bruta_r;
        case (indice_r)
            SENSOR_DIREITA:  lim_s = (coord_s >= DIST_MAX) ? '0 : DIST_MAX - coord_s;
            SENSOR_ESQUERDA: lim_s = coord_s;
            default:         lim_s = DIST_MAX;
        endcase
        if (d_min_s < lim_s) begin
            dist_limitada_s = d_min_s;
        end else begin
            dist_limitada_s = lim_s;
        end
    end

    // Measurement sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r      <= OCIOSO;
            indice_r      <= SENSOR_FRENTE;
            timer_r       <= '0;
            dist_bruta_r  <= '0;
            dist_frente_r <= '0;
            dist_dir_r    <= '0;
            dist_esq_r    <= '0;
            pos_x_r       <= '0;
            pos_y_r       <= '0;
            dir_r         <= 1'b0;
            novo_dado_r   <= 1'b0;
            ocupado_r     <= 1'b0;
            disparo_r     <= 3'b000;
            timeout_r     <= 3'b000;
        end else begin
            novo_dado_r <= 1'b0;
            case (estado_r)
                OCIOSO: begin
                    if (partida_s) begin
                        pos_x_r   <= posicaoX;
                        pos_y_r   <= posicaoY;
                        dir_r     <= direcao;
                        timeout_r <= 3'b000;
                        indice_r  <= SENSOR_FRENTE;
                        timer_r   <= '0;
                        disparo_r <= sensor_onehot(SENSOR_FRENTE);
                        ocupado_r <= 1'b1;
                        estado_r  <= DISPARO;
                    end
                end
                DISPARO: begin
                    if (timer_r == DISPARO_ULTIMO) begin
                        disparo_r <= 3'b000;
                        timer_r   <= '0;
                        estado_r  <= ESPERA_ECO;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                ESPERA_ECO: begin
                    if (sobe_s) begin
                        timer_r  <= '0;
                        estado_r <= MEDINDO;
                    end else if (timer_r == TIMEOUT_ULTIMO) begin
                        timeout_r[indice_r] <= 1'b1;
                        dist_bruta_r        <= DIST_MAX;
                        estado_r            <= PROXIMO;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                MEDINDO: begin
                    // The falling-edge cycle itself counts toward the width.
                    if (desce_s) begin
                        dist_bruta_r <= celula_prox_s;
                        estado_r     <= PROXIMO;
                    end else if (timer_r == TIMEOUT_ULTIMO) begin
                        dist_bruta_r <= DIST_MAX;
                        estado_r     <= PROXIMO;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                PROXIMO: begin
                    case (indice_r)
                        SENSOR_DIREITA:  dist_dir_r    <= dist_limitada_s;
                        SENSOR_ESQUERDA: dist_esq_r    <= dist_limitada_s;
                        default:         dist_frente_r <= dist_limitada_s;
                    endcase
                    if (indice_r == SENSOR_ESQUERDA) begin
                        estado_r <= ENTREGA;
                    end else begin
                        indice_r  <= indice_r + 2'd1;
                        disparo_r <= sensor_onehot(indice_r + 2'd1);
                        timer_r   <= '0;
                        estado_r  <= DISPARO;
                    end
                end
                ENTREGA: begin
                    if (mapa.operacaoFinalizada) begin
                        novo_dado_r <= 1'b1;
                        estado_r    <= AGUARDA;
                    end
                end
                AGUARDA: begin
                    if (!mapa.operacaoFinalizada) begin
                        ocupado_r <= 1'b0;
                        estado_r  <= OCIOSO;
                    end
                end
                default: begin
                    disparo_r <= 3'b000;
                    ocupado_r <= 1'b0;
                    estado_r  <= OCIOSO;
                end
            endcase
        end
    end

    assign disparo                  = disparo_r;
    assign timeoutSensor            = timeout_r;
    assign ocupado                  = ocupado_r;
    assign mapa.novoDado            = novo_dado_r;
    assign mapa.posicaoAtualnoEixoX = pos_x_r;
    assign mapa.posicaoAtualnoEixoY = pos_y_r;
    assign mapa.direcaoAtual        = dir_r;
    assign mapa.distanciaFrente     = dist_frente_r;
    assign mapa.distanciaDireita    = dist_dir_r;
    assign mapa.distanciaEsquerda   = dist_esq_r;
endmodule

// File: tb/tb_medidor_distancias.sv
// Self-checking bench for medidor_distancias with small timing parameters.
// The bench answers each trigger with an echo of a chosen width; a reference
// model derives the expected sample from echo widths and pose, and each
// scenario also pins hand-computed distances.
module tb_medidor_distancias;
    localparam int TM = 20;
    localparam int W  = 8;
    localparam int C  = 10;
    localparam int D  = 3;
    localparam int T  = 200;

    logic         clock = 1'b0;
    logic         reset;
    logic         iniciar;
    logic [W-1:0] posicaoX, posicaoY;
    logic         direcao;
    logic [2:0]   eco;
    logic [2:0]   disparo;
    logic [2:0]   timeoutSensor;
    logic         ocupado;

    medidor_distancias_if #(.tamanhoDistancia(W)) mapa_if ();

    medidor_distancias #(
        .TamanhoMalha     (TM),
        .tamanhoDistancia (W),
        .CiclosPorCelula  (C),
        .CiclosDisparo    (D),
        .CiclosTimeout    (T)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .posicaoX      (posicaoX),
        .posicaoY      (posicaoY),
        .direcao       (direcao),
        .eco           (eco),
        .disparo       (disparo),
        .timeoutSensor (timeoutSensor),
        .ocupado       (ocupado),
        .mapa          (mapa_if)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int fails  = 0;
    int pulsos = 0;
    int exp_d [3];
    int exp_to, exp_x, exp_y, exp_dir;

    task automatic check(input string nome, input int got, input int expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nome, got, expv);
        end
    endtask

    // Distance in cells from the echo width, then grid clamping.
    function automatic int modelo(input int largura, input int sensor,
                                  input int x, input int y, input int dir);
        int d, c, lim;
        if (largura == 0 || largura >= T) d = TM - 1;
        else d = largura / C;
        if (d > TM - 1) d = TM - 1;
        if (d < 1) d = 1;
        c = dir ? x : y;
        if (sensor == 1) lim = (c >= TM - 1) ? 0 : TM - 1 - c;
        else if (sensor == 2) lim = c;
        else lim = TM - 1;
        return (d < lim) ? d : lim;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("disparo_onehot", int'($countones(disparo) <= 1), 1);
            if (disparo != 3'b000) check("ocupado_disparo", ocupado, 1);
            if (mapa_if.novoDado === 1'b1) begin
                pulsos++;
                check("m_frente",   mapa_if.distanciaFrente,   exp_d[0]);
                check("m_direita",  mapa_if.distanciaDireita,  exp_d[1]);
                check("m_esquerda", mapa_if.distanciaEsquerda, exp_d[2]);
                check("m_timeout",  timeoutSensor,             exp_to);
                check("m_pose_x",   mapa_if.posicaoAtualnoEixoX, exp_x);
                check("m_pose_y",   mapa_if.posicaoAtualnoEixoY, exp_y);
                check("m_dir",      mapa_if.direcaoAtual,      exp_dir);
            end
        end
    end

    task automatic sensor(input int i, input int w);
        int n;
        n = 0;
        while (disparo !== (3'b001 << i) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("disparo_sel", disparo, 3'b001 << i);
        n = 0;
        while (disparo[i] === 1'b1 && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("disparo_largura", n, D);
        repeat (4) @(negedge clock);
        if (w > 0) begin
            eco[i] = 1'b1;
            repeat (w) @(negedge clock);
            eco[i] = 1'b0;
        end
    endtask

    task automatic iniciar_ciclo(input int x, input int y, input int dir);
        posicaoX = W'(x);
        posicaoY = W'(y);
        direcao  = dir[0];
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic run_ciclo(input int x, input int y, input int dir,
                             input int w0, input int w1, input int w2, input int espera,
                             input int e0, input int e1, input int e2, input int et);
        int p0, n;
        exp_d[0] = modelo(w0, 0, x, y, dir);
        exp_d[1] = modelo(w1, 1, x, y, dir);
        exp_d[2] = modelo(w2, 2, x, y, dir);
        exp_to   = {29'd0, w2 == 0, w1 == 0, w0 == 0};
        exp_x = x; exp_y = y; exp_dir = dir;
        p0 = pulsos;
        mapa_if.operacaoFinalizada = (espera > 0) ? 1'b0 : 1'b1;
        iniciar_ciclo(x, y, dir);
        check("ocupado_inicio", ocupado, 1);
        sensor(0, w0);
        sensor(1, w1);
        sensor(2, w2);
        if (espera > 0) begin
            repeat (espera) @(negedge clock);
            check("novoDado_retido", pulsos - p0, 0);
            check("ocupado_entrega", ocupado, 1);
            mapa_if.operacaoFinalizada = 1'b1;
            @(negedge clock);
            check("novoDado_apos_pronto", mapa_if.novoDado, 1);
        end else begin
            n = 0;
            while (mapa_if.novoDado !== 1'b1 && n < 300) begin
                @(negedge clock);
                n++;
            end
            check("novoDado_visto", mapa_if.novoDado, 1);
        end
        mapa_if.operacaoFinalizada = 1'b0;
        @(negedge clock);
        check("novoDado_pulso_unico", mapa_if.novoDado, 0);
        check("ocupado_libera", ocupado, 0);
        mapa_if.operacaoFinalizada = 1'b1;
        @(negedge clock);
        check("lit_frente",   mapa_if.distanciaFrente,   e0);
        check("lit_direita",  mapa_if.distanciaDireita,  e1);
        check("lit_esquerda", mapa_if.distanciaEsquerda, e2);
        check("lit_timeout",  timeoutSensor,             et);
        check("pulsos",       pulsos - p0,               1);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        iniciar  = 1'b0;
        posicaoX = '0;
        posicaoY = '0;
        direcao  = 1'b0;
        eco      = 3'b000;
        mapa_if.operacaoFinalizada = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_disparo", disparo, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_novoDado", mapa_if.novoDado, 0);
        check("rst_frente", mapa_if.distanciaFrente, 0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_ocupado", ocupado, 0);

        // Nominal: 40/30/20 cycles -> 4/3/2 cells.
        run_ciclo(5, 5, 1, 40, 30, 20, 0, 4, 3, 2, 0);
        // Right clamped to 1 near the right wall; left 25 -> 2.
        run_ciclo(18, 3, 1, 40, 80, 25, 0, 4, 1, 2, 0);
        // Front never echoes -> timeout flag and 19.
        run_ciclo(5, 5, 1, 0, 30, 20, 0, 19, 3, 2, 1);
        // Short echo raised to 1; left against the wall -> 0.
        run_ciclo(0, 7, 1, 5, 30, 20, 0, 1, 3, 0, 0);
        // Horizontal pose (c = Y = 4), mapper busy for 50 cycles.
        run_ciclo(10, 4, 0, 15, 60, 50, 50, 1, 6, 4, 0);

        // Reset while measuring the right sensor.
        mapa_if.operacaoFinalizada = 1'b1;
        iniciar_ciclo(5, 5, 1);
        sensor(0, 40);
        n = 0;
        while (disparo !== 3'b010 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("rst_mid_disparo_dir", disparo, 2);
        while (disparo !== 3'b000 && n < 400) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        eco[1] = 1'b1;
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_disparo", disparo, 0);
        check("rst_mid_ocupado", ocupado, 0);
        check("rst_mid_frente", mapa_if.distanciaFrente, 0);
        check("rst_mid_esquerda", mapa_if.distanciaEsquerda, 0);
        check("rst_mid_pose_x", mapa_if.posicaoAtualnoEixoX, 0);
        check("rst_mid_timeout", timeoutSensor, 0);
        eco = 3'b000;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_ciclo(5, 5, 1, 40, 30, 20, 0, 4, 3, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
